// File: rtl/fib_request_arbiter.sv
// Round-robin arbiter feeding one shared iterative Fibonacci adder.
// One request is served at a time; the result is returned over a valid/ready channel.
module fib_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDX_W   = 5,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_value,
    output logic                     rsp_overflow,
    output logic                     busy,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [IDX_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_a_ovf;
    logic              r_b_ovf;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_value;
    logic              r_rsp_overflow;
    logic              r_busy;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic [ID_W-1:0]    w_idx;
    logic               w_grant_any;
    logic               w_accept;
    logic [IDX_W-1:0]   w_sel_index;
    logic [WIDTH:0]     w_sum;

    // Search starts just after the last winner, so a requester that keeps
    // req_valid high after its grant drops to the lowest priority.
    always_comb begin
        w_grant     = '0;
        w_grant_id  = '0;
        w_grant_any = 1'b0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_grant_any && req_valid[w_idx]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_idx;
            end
        end
        if (r_state == S_IDLE && w_grant_any) begin
            w_grant[w_grant_id] = 1'b1;
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; the request side is accepted only through req_ready,
    // and the response fields are frozen while rsp_valid waits for rsp_ready.
    assign w_accept    = (r_state == S_IDLE) && w_grant_any;
    assign w_sel_index = req_index[w_grant_id*IDX_W +: IDX_W];
    assign w_sum       = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= ID_W'(NUM_REQ - 1);
            r_id           <= '0;
            r_cnt          <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_a_ovf        <= 1'b0;
            r_b_ovf        <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_value    <= '0;
            r_rsp_overflow <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rr_ptr <= w_grant_id;
                        r_id     <= w_grant_id;
                        r_cnt    <= w_sel_index;
                        r_a      <= '0;
                        r_b      <= WIDTH'(1);
                        r_a_ovf  <= 1'b0;
                        r_b_ovf  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_rsp_value    <= r_a_ovf ? '0 : r_a;
                        r_rsp_overflow <= r_a_ovf;
                        r_rsp_id       <= r_id;
                        r_rsp_valid    <= 1'b1;
                        r_state        <= S_RESP;
                    end else begin
                        // Overflow flags are sticky and follow their value down the shift.
                        r_a     <= r_b;
                        r_a_ovf <= r_b_ovf;
                        r_b     <= w_sum[WIDTH-1:0];
                        r_b_ovf <= r_a_ovf | r_b_ovf | w_sum[WIDTH];
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = w_grant;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_value    = r_rsp_value;
    assign rsp_overflow = r_rsp_overflow;
    assign busy         = r_busy;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_fib_request_arbiter.sv
// Directed bench for fib_request_arbiter: a driver issues requests and pushes
// hand-computed responses; a monitor pops and compares on every response.
module tb_fib_request_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int IDX_W   = 5;
  localparam int ID_W    = 2;
  localparam int E_W     = 32 + ID_W + 1 + WIDTH;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*IDX_W-1:0] req_index;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_value;
  logic                     rsp_overflow;
  logic                     busy;
  logic [1:0]               dbg_state;

  fib_request_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_value(rsp_value), .rsp_overflow(rsp_overflow),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  // entry = {expected first-valid cycle, id, overflow, value}
  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] cur;
  logic           in_rsp   = 1'b0;
  logic           have_exp = 1'b0;
  int             last_hs_cyc = -100;

  always @(negedge clk) begin
    if (reset) begin
      in_rsp = 1'b0;
    end else if (rsp_valid) begin
      if (!in_rsp) begin
        in_rsp = 1'b1;
        if (exp_q.size() == 0) begin
          have_exp = 1'b0;
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: id %0d value %0d ovf %0d, none required", rsp_id, rsp_value, rsp_overflow);
          cur = {32'(cycle), rsp_id, rsp_overflow, rsp_value};
        end else begin
          have_exp = 1'b1;
          cur = exp_q[0];
          check("rsp_latency", 64'(cycle), 64'(cur[E_W-1 -: 32]));
          check("rsp_id", 64'(rsp_id), 64'(cur[WIDTH+ID_W:WIDTH+1]));
          check("rsp_value", 64'(rsp_value), 64'(cur[WIDTH-1:0]));
          check("rsp_overflow", 64'(rsp_overflow), 64'(cur[WIDTH]));
        end
      end else begin
        check("rsp_stable", 64'({rsp_id, rsp_overflow, rsp_value}), 64'(cur[ID_W+WIDTH:0]));
      end
      if (rsp_ready) begin
        if (have_exp) void'(exp_q.pop_front());
        in_rsp      = 1'b0;
        last_hs_cyc = cycle;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(int id, int n, logic [WIDTH-1:0] val, logic ovf, bit push, bit same_cycle);
    int  start;
    bit  got;
    req_index[id*IDX_W +: IDX_W] = IDX_W'(n);
    req_valid[id] = 1'b1;
    start = cycle;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    check("grant_seen", 64'(got), 64'd1);
    if (got) begin
      check("grant_onehot", 64'(req_ready), 64'(1 << id));
      if (same_cycle) check("grant_same_cycle", 64'(cycle), 64'(start));
      if (push) exp_q.push_back({32'(cycle + n + 2), ID_W'(id), ovf, val});
    end
    @(posedge clk); #1 req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check("drain", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rsp_valid_seen", 64'(seen), 64'd1);
  endtask

  // ---------------- directed vectors ----------------
  int          vec_id [6] = '{1, 2, 3, 0, 1, 2};
  int          vec_n  [6] = '{0, 1, 13, 14, 31, 2};
  int          vec_val[6] = '{0, 1, 233, 0, 0, 1};
  logic        vec_ovf[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  int          fair_val[4] = '{1, 2, 3, 5};

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    reset     = 1'b1;
    req_valid = '0;
    req_index = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_id", 64'(rsp_id), 64'd0);
    check("reset_rsp_value", 64'(rsp_value), 64'd0);
    check("reset_rsp_overflow", 64'(rsp_overflow), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;

    // F(10) = 55 from requester 0, then boundary indices
    do_req(0, 10, 8'd55, 1'b0, 1'b1, 1'b1);
    drain();
    for (int v = 0; v < 6; v++) begin
      do_req(vec_id[v], vec_n[v], WIDTH'(vec_val[v]), vec_ovf[v], 1'b1, 1'b1);
      drain();
    end

    // fairness: all four requesters held high
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_index[i*IDX_W +: IDX_W] = IDX_W'(i + 2);
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (req_ready != '0) got = 1'b1;
      end
      check("fair_grant_seen", 64'(got), 64'd1);
      if (got) begin
        check("fair_grant_order", 64'(req_ready), 64'(1 << (g % 4)));
        if (g > 0) check("fair_grant_gap", 64'(cycle), 64'(last_hs_cyc + 1));
        exp_q.push_back({32'(cycle + (g % 4) + 4), ID_W'(g % 4), 1'b0, WIDTH'(fair_val[g % 4])});
      end
    end
    @(posedge clk); #1 req_valid = '0;
    drain();

    // backpressure: F(5) held for several cycles while requester 2 waits
    rsp_ready = 1'b0;
    do_req(1, 5, 8'd5, 1'b0, 1'b1, 1'b1);
    req_index[2*IDX_W +: IDX_W] = IDX_W'(2);
    req_valid[2] = 1'b1;
    wait_rsp_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_ready_zero", 64'(req_ready), 64'd0);
      check("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[2]) got = 1'b1;
    end
    check("bp_next_grant_seen", 64'(got), 64'd1);
    if (got) begin
      check("bp_next_grant_gap", 64'(cycle), 64'(last_hs_cyc + 1));
      exp_q.push_back({32'(cycle + 4), ID_W'(2), 1'b0, 8'd1});
    end
    @(posedge clk); #1 req_valid[2] = 1'b0;
    drain();

    // reset during RUN of F(20): no response, priority restarts at 0
    do_req(0, 20, 8'd0, 1'b1, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    req_index[1*IDX_W +: IDX_W] = IDX_W'(3);
    req_valid[1] = 1'b1;
    do_req(0, 1, 8'd1, 1'b0, 1'b1, 1'b1);
    do_req(1, 3, 8'd2, 1'b0, 1'b1, 1'b0);
    drain();

    // reset coinciding with the response handshake
    rsp_ready = 1'b0;
    do_req(3, 3, 8'd2, 1'b0, 1'b1, 1'b1);
    wait_rsp_valid();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    reset     = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rh_req_ready", 64'(req_ready), 64'd0);
    check("rh_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rh_rsp_id", 64'(rsp_id), 64'd0);
    check("rh_rsp_value", 64'(rsp_value), 64'd0);
    check("rh_rsp_overflow", 64'(rsp_overflow), 64'd0);
    check("rh_busy", 64'(busy), 64'd0);
    check("rh_state", 64'(dbg_state), 64'd0);
    repeat (20) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fib_request_arbiter.md
Name: fib_request_arbiter

Overview:
- Shared Fibonacci compute engine with a round-robin arbiter in front of it.
- Up to NUM_REQ requesters each ask for term F(n); the block grants one at a time and sequences an iterative two-register add datapath, one add per cycle.
- It returns F(n) with the requester ID and an overflow flag over a valid/ready response channel.
- Sits between control masters and the sequence datapath, so a single adder is time-shared.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, result width in bits; values above 2^WIDTH-1 are overflow.
- IDX_W, 5, width of requested index n (n = 0..2^IDX_W-1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request strobe.
- req_index  input  NUM_REQ*IDX_W  packed term indices; requester i uses bits [i*IDX_W +: IDX_W].
- req_ready  output  NUM_REQ  one-hot grant/accept; request i is accepted when req_valid[i] & req_ready[i].
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  clog2(NUM_REQ)  requester that owns the result.
- rsp_value  output  WIDTH  F(n), or 0 on overflow.
- rsp_overflow  output  1  F(n) exceeded 2^WIDTH-1.
- busy  output  1  high in RUN or RESP.

Behaviour:
- Reset values: state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 has highest priority first), req_ready=0, rsp_valid=0, rsp_id=0, rsp_value=0, rsp_overflow=0, busy=0.
- Reset mid-operation aborts the computation and drops any pending response.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - req_ready is combinational and one-hot: the first i with req_valid[i]=1, searching from rr_ptr+1 upward with wrap.
  - req_ready is all-zero if no requests are pending, and all-zero outside IDLE.
  - On accept: rr_ptr<=i, id<=i, cnt<=req_index[i], a<=0, b<=1, a_ovf<=0, b_ovf<=0; go to RUN.
- RUN, per cycle:
  - If cnt==0: latch rsp_value <= (a_ovf ? 0 : a), rsp_overflow <= a_ovf, rsp_id <= id; go to RESP.
  - Else: a<=b, a_ovf<=b_ovf, b<=(a+b) mod 2^WIDTH, b_ovf <= a_ovf | b_ovf | carry-out of a+b, cnt<=cnt-1.
- RESP:
  - rsp_valid=1.
  - rsp_id, rsp_value and rsp_overflow are held stable until rsp_ready=1; on that cycle go to IDLE.
  - No new grant is issued in the handshake cycle; the next grant is evaluated in IDLE the following cycle.
- Latency: request accepted at cycle T gives rsp_valid high at T+n+2 (n=0 gives T+2).
- Overflow is tracked on the a register only. Overflow of b beyond the requested term does not flag; e.g. with WIDTH=8, F(13)=233 is not overflow even though b=377 internally.
- Once set, an ovf flag is sticky through subsequent shifts.
- Requesters must hold req_valid and their req_index stable until accepted. A requester dropping req_valid before accept is simply skipped.
- A requester re-asserting immediately after its own grant gets lowest priority next round (fairness).
- Simultaneous reset and rsp_ready: reset wins.
- rsp_ready while rsp_valid=0 is ignored.

Test Plan:
- Reset, then requester 0 asks n=10 (WIDTH=8) -> req_ready=4'b0001 same cycle; rsp_valid at T+12; rsp_value=55, rsp_id=0, rsp_overflow=0.
- Boundaries: n=0 -> 0 at T+2; n=1 -> 1; n=13 -> 233 no overflow; n=14 -> rsp_value=0, rsp_overflow=1; n=31 -> overflow=1.
- All four requesters hold req_valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,...; each grant waits for the previous response handshake plus one cycle.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and all rsp_* fields stable; req_ready stays 0; on release, the next grant follows one cycle later.
- Assert reset for one cycle during RUN of an n=20 request -> no response is produced; busy=0 next cycle; requester 0 is granted first after reset even if rr_ptr was 0.
- Reset asserted in the same cycle as the rsp_ready handshake -> all outputs return to their reset values; no further response is produced.
